// File: rtl/mc_control.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB plus an MDU wait state.
// Only the state and latency counter are stored; every control output is decoded from state and IR.
module mc_control #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        cmp_true,
  output logic        IR_WE,
  output logic        PC_WE,
  output logic [1:0]  NPCsel,
  output logic [1:0]  NPCOp,
  output logic [3:0]  CMPOp,
  output logic [1:0]  ExtOp,
  output logic [1:0]  ALUasel,
  output logic [1:0]  ALUbsel,
  output logic [3:0]  ALUOp,
  output logic        DM_RE,
  output logic        DM_WE,
  output logic [1:0]  DMOp,
  output logic [1:0]  A3sel,
  output logic [1:0]  WDsel,
  output logic        GRF_WE,
  output logic        MD_start,
  output logic [1:0]  MD_op,
  output logic [1:0]  HILO_WE,
  output logic        HILOsel,
  output logic        busy
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, MDU_WAIT} state_t;
  typedef enum logic [3:0] {
    K_NOP, K_BR, K_J, K_JR, K_JAL, K_JALR, K_ALU, K_MF, K_MT, K_MD, K_LD, K_ST
  } kind_t;

  // Counter is loaded with LAT-1 in EXEC; MDU_WAIT finishes on the cycle it reads 1.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  assign op    = IR[31:26];
  assign funct = IR[5:0];
  assign rt    = IR[20:16];

  logic unused_ir;
  assign unused_ir = ^{IR[25:21], IR[15:6]};

  kind_t            kind;
  logic [3:0]       cmp_op;
  logic [1:0]       ext_op;
  logic [1:0]       alu_a;
  logic [1:0]       alu_b;
  logic [3:0]       alu_op;
  logic [1:0]       dm_op;
  logic [1:0]       a3_sel;
  logic [1:0]       wd_sel;
  logic [1:0]       hilo_we;
  logic             hi_sel;
  logic [CNT_W-1:0] md_load;

  // funct[1] separates div/divu (0x1a/0x1b) from mult/multu (0x18/0x19).
  assign md_load = funct[1] ? DIV_LOAD : MULT_LOAD;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can leave it holding a value (latch).
    kind    = K_NOP;
    cmp_op  = '0;
    ext_op  = '0;
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = '0;
    dm_op   = '0;
    a3_sel  = '0;
    wd_sel  = '0;
    hilo_we = '0;
    hi_sel  = 1'b0;
    case (op)
      6'h00:
        case (funct)
          6'h21: kind = K_ALU;
          6'h23: begin kind = K_ALU; alu_op = 4'b0001; end
          6'h24: begin kind = K_ALU; alu_op = 4'b0010; end
          6'h2a: begin kind = K_ALU; alu_op = 4'b0111; end
          6'h00: begin kind = K_ALU; alu_a = 2'd2; alu_b = 2'd3; alu_op = 4'b0110; end
          6'h08: kind = K_JR;
          6'h09: begin kind = K_JALR; alu_a = 2'd1; alu_b = 2'd2; end
          6'h10: begin kind = K_MF; wd_sel = 2'd2; hi_sel = 1'b1; end
          6'h12: begin kind = K_MF; wd_sel = 2'd2; end
          6'h11: begin kind = K_MT; hilo_we = 2'b10; end
          6'h13: begin kind = K_MT; hilo_we = 2'b01; end
          6'h18, 6'h19, 6'h1a, 6'h1b: kind = K_MD;
          default: ;
        endcase
      6'h01:
        if (rt == 5'd0) begin
          kind = K_BR; cmp_op = 4'd4;
        end else if (rt == 5'd1) begin
          kind = K_BR; cmp_op = 4'd1;
        end
      6'h04: kind = K_BR;
      6'h05: begin kind = K_BR; cmp_op = 4'd5; end
      6'h06: begin kind = K_BR; cmp_op = 4'd3; end
      6'h07: begin kind = K_BR; cmp_op = 4'd2; end
      6'h02: kind = K_J;
      6'h03: begin kind = K_JAL; alu_a = 2'd1; alu_b = 2'd2; a3_sel = 2'd3; end
      6'h09: begin kind = K_ALU; alu_b = 2'd1; a3_sel = 2'd1; end
      6'h0c: begin kind = K_ALU; ext_op = 2'd1; alu_b = 2'd1; alu_op = 4'b0010; a3_sel = 2'd1; end
      6'h0d: begin kind = K_ALU; ext_op = 2'd1; alu_b = 2'd1; alu_op = 4'b0011; a3_sel = 2'd1; end
      6'h0f: begin kind = K_ALU; ext_op = 2'd2; alu_b = 2'd1; a3_sel = 2'd1; end
      6'h23: begin kind = K_LD; alu_b = 2'd1; a3_sel = 2'd1; wd_sel = 2'd1; end
      6'h20: begin kind = K_LD; alu_b = 2'd1; a3_sel = 2'd1; wd_sel = 2'd1; dm_op = 2'd2; end
      6'h24: begin kind = K_LD; alu_b = 2'd1; a3_sel = 2'd1; wd_sel = 2'd1; dm_op = 2'd3; end
      6'h2b: begin kind = K_ST; alu_b = 2'd1; end
      6'h28: begin kind = K_ST; alu_b = 2'd1; dm_op = 2'd1; end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      case (state)
        FETCH:  state <= DECODE;
        DECODE: state <= (kind inside {K_NOP, K_BR, K_J, K_JR}) ? FETCH : EXEC;
        EXEC:
          case (kind)
            K_LD, K_ST: state <= MEM;
            K_MT:       state <= FETCH;
            K_MD: begin
              cnt   <= md_load;
              state <= (md_load == '0) ? FETCH : MDU_WAIT;
            end
            default:    state <= WB;
          endcase
        MEM:    state <= (kind == K_LD) ? WB : FETCH;
        WB:     state <= FETCH;
        MDU_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin
    IR_WE    = 1'b0;
    PC_WE    = 1'b0;
    NPCsel   = '0;
    NPCOp    = '0;
    CMPOp    = '0;
    ExtOp    = '0;
    ALUasel  = '0;
    ALUbsel  = '0;
    ALUOp    = '0;
    DM_RE    = 1'b0;
    DM_WE    = 1'b0;
    DMOp     = '0;
    A3sel    = '0;
    WDsel    = '0;
    GRF_WE   = 1'b0;
    MD_start = 1'b0;
    MD_op    = '0;
    HILO_WE  = '0;
    HILOsel  = 1'b0;
    busy     = 1'b0;
    case (state)
      FETCH: IR_WE = 1'b1;
      DECODE: begin
        ExtOp = ext_op;
        CMPOp = cmp_op;
        case (kind)
          K_BR:  begin PC_WE = 1'b1; NPCsel = cmp_true ? 2'd1 : 2'd0; end
          K_J:   begin PC_WE = 1'b1; NPCsel = 2'd1; NPCOp = 2'd1; end
          K_JR:  begin PC_WE = 1'b1; NPCsel = 2'd2; end
          K_NOP: PC_WE = 1'b1;
          default: ;
        endcase
      end
      EXEC: begin
        ExtOp   = ext_op;
        ALUasel = alu_a;
        ALUbsel = alu_b;
        ALUOp   = alu_op;
        case (kind)
          K_MT: begin HILO_WE = hilo_we; PC_WE = 1'b1; end
          K_MD: begin
            MD_start = 1'b1;
            MD_op    = funct[1:0];
            PC_WE    = (md_load == '0);
          end
          default: ;
        endcase
      end
      MEM: begin
        ExtOp   = ext_op;
        ALUasel = alu_a;
        ALUbsel = alu_b;
        ALUOp   = alu_op;
        DMOp    = dm_op;
        DM_RE   = (kind == K_LD);
        DM_WE   = (kind == K_ST);
        PC_WE   = (kind == K_ST);
      end
      WB: begin
        ExtOp   = ext_op;
        ALUasel = alu_a;
        ALUbsel = alu_b;
        ALUOp   = alu_op;
        DMOp    = dm_op;
        GRF_WE  = 1'b1;
        A3sel   = a3_sel;
        WDsel   = wd_sel;
        HILOsel = hi_sel;
        PC_WE   = 1'b1;
        if (kind == K_JAL) begin
          NPCsel = 2'd1;
          NPCOp  = 2'd1;
        end else if (kind == K_JALR) begin
          NPCsel = 2'd2;
        end
      end
      MDU_WAIT: begin
        busy  = 1'b1;
        PC_WE = (cnt == CNT_W'(1));
      end
      default: ;
    endcase
    // A reset cycle aborts the instruction, so none of its side effects may commit.
    if (reset) begin
      IR_WE    = 1'b0;
      PC_WE    = 1'b0;
      DM_RE    = 1'b0;
      DM_WE    = 1'b0;
      GRF_WE   = 1'b0;
      MD_start = 1'b0;
      HILO_WE  = '0;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: two instances (default latencies, and MULT=3/DIV=1) run
// directed plus random instruction streams against an instruction-level reference model.
module tb_mc_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       ir_we;
    logic       pc_we;
    logic [1:0] npcsel;
    logic [1:0] npcop;
    logic [3:0] cmpop;
    logic [1:0] extop;
    logic [1:0] alua;
    logic [1:0] alub;
    logic [3:0] aluop;
    logic       dm_re;
    logic       dm_we;
    logic [1:0] dmop;
    logic [1:0] a3sel;
    logic [1:0] wdsel;
    logic       grf_we;
    logic       md_start;
    logic [1:0] md_op;
    logic [1:0] hilo_we;
    logic       hilosel;
    logic       busy;
  } ctl_t;

  typedef struct {
    ctl_t        v;
    bit          rst;
    logic [31:0] ins;
    int          k;
  } exp_t;

  typedef enum {K_NOP, K_BR, K_J, K_JR, K_JAL, K_JALR, K_ALU, K_MF, K_MT, K_MD, K_LD, K_ST} kind_e;

  typedef struct {
    kind_e      kind;
    int         lat;
    logic [1:0] ext;
    logic [3:0] cmp;
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] op;
    logic [1:0] a3;
    logic [1:0] wd;
    logic [1:0] dmop;
    logic [1:0] mdop;
    logic [1:0] hilo;
    logic       hisel;
  } info_t;

  logic        rst_s [2];
  logic [31:0] ir_s  [2];
  logic        cmp_s [2];

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  ctl_t en_mask;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic       ir_we, pc_we, dm_re, dm_we, grf_we, md_start, hilosel, busy;
    logic [1:0] npcsel, npcop, extop, alua, alub, dmop, a3sel, wdsel, md_op, hilo_we;
    logic [3:0] cmpop, aluop;
    ctl_t       o;
    mc_control #(
      .MULT_CYCLES(g == 0 ? 5 : 3),
      .DIV_CYCLES (g == 0 ? 10 : 1),
      .CNT_W      (4)
    ) u_dut (
      .clk(clk), .reset(rst_s[g]), .IR(ir_s[g]), .cmp_true(cmp_s[g]),
      .IR_WE(ir_we), .PC_WE(pc_we), .NPCsel(npcsel), .NPCOp(npcop), .CMPOp(cmpop),
      .ExtOp(extop), .ALUasel(alua), .ALUbsel(alub), .ALUOp(aluop),
      .DM_RE(dm_re), .DM_WE(dm_we), .DMOp(dmop), .A3sel(a3sel), .WDsel(wdsel),
      .GRF_WE(grf_we), .MD_start(md_start), .MD_op(md_op), .HILO_WE(hilo_we),
      .HILOsel(hilosel), .busy(busy)
    );
    assign o = {ir_we, pc_we, npcsel, npcop, cmpop, extop, alua, alub, aluop, dm_re, dm_we,
                dmop, a3sel, wdsel, grf_we, md_start, md_op, hilo_we, hilosel, busy};
  end

  // Instruction-level reference: what class an instruction is, how long it takes, and its control fields.
  function automatic info_t classify(input logic [31:0] ins, input int mul_lat, input int div_lat);
    info_t f;
    f.kind = K_NOP; f.lat = 2; f.ext = 0; f.cmp = 0; f.a = 0; f.b = 0; f.op = 0;
    f.a3 = 0; f.wd = 0; f.dmop = 0; f.mdop = 0; f.hilo = 0; f.hisel = 0;
    case (ins[31:26])
      6'h00:
        case (ins[5:0])
          6'h21: begin f.kind = K_ALU; f.lat = 4; end
          6'h23: begin f.kind = K_ALU; f.lat = 4; f.op = 4'b0001; end
          6'h24: begin f.kind = K_ALU; f.lat = 4; f.op = 4'b0010; end
          6'h2a: begin f.kind = K_ALU; f.lat = 4; f.op = 4'b0111; end
          6'h00: begin f.kind = K_ALU; f.lat = 4; f.a = 2; f.b = 3; f.op = 4'b0110; end
          6'h08: f.kind = K_JR;
          6'h09: begin f.kind = K_JALR; f.lat = 4; f.a = 1; f.b = 2; end
          6'h10: begin f.kind = K_MF; f.lat = 4; f.wd = 2; f.hisel = 1; end
          6'h12: begin f.kind = K_MF; f.lat = 4; f.wd = 2; end
          6'h11: begin f.kind = K_MT; f.lat = 3; f.hilo = 2'b10; end
          6'h13: begin f.kind = K_MT; f.lat = 3; f.hilo = 2'b01; end
          6'h18: begin f.kind = K_MD; f.lat = mul_lat + 2; f.mdop = 0; end
          6'h19: begin f.kind = K_MD; f.lat = mul_lat + 2; f.mdop = 1; end
          6'h1a: begin f.kind = K_MD; f.lat = div_lat + 2; f.mdop = 2; end
          6'h1b: begin f.kind = K_MD; f.lat = div_lat + 2; f.mdop = 3; end
          default: ;
        endcase
      6'h01: begin
        if (ins[20:16] == 5'd0) begin f.kind = K_BR; f.cmp = 4; end
        if (ins[20:16] == 5'd1) begin f.kind = K_BR; f.cmp = 1; end
      end
      6'h04: f.kind = K_BR;
      6'h05: begin f.kind = K_BR; f.cmp = 5; end
      6'h06: begin f.kind = K_BR; f.cmp = 3; end
      6'h07: begin f.kind = K_BR; f.cmp = 2; end
      6'h02: f.kind = K_J;
      6'h03: begin f.kind = K_JAL; f.lat = 4; f.a = 1; f.b = 2; f.a3 = 3; end
      6'h09: begin f.kind = K_ALU; f.lat = 4; f.b = 1; f.a3 = 1; end
      6'h0c: begin f.kind = K_ALU; f.lat = 4; f.b = 1; f.a3 = 1; f.ext = 1; f.op = 4'b0010; end
      6'h0d: begin f.kind = K_ALU; f.lat = 4; f.b = 1; f.a3 = 1; f.ext = 1; f.op = 4'b0011; end
      6'h0f: begin f.kind = K_ALU; f.lat = 4; f.b = 1; f.a3 = 1; f.ext = 2; end
      6'h23: begin f.kind = K_LD; f.lat = 5; f.b = 1; f.a3 = 1; f.wd = 1; end
      6'h20: begin f.kind = K_LD; f.lat = 5; f.b = 1; f.a3 = 1; f.wd = 1; f.dmop = 2; end
      6'h24: begin f.kind = K_LD; f.lat = 5; f.b = 1; f.a3 = 1; f.wd = 1; f.dmop = 3; end
      6'h2b: begin f.kind = K_ST; f.lat = 4; f.b = 1; end
      6'h28: begin f.kind = K_ST; f.lat = 4; f.b = 1; f.dmop = 1; end
      default: ;
    endcase
    return f;
  endfunction

  // Expected controls for cycle k of an instruction (k=0 is its fetch cycle).
  function automatic ctl_t exp_at(input info_t f, input int k, input logic c);
    ctl_t e;
    bit   mem;
    e   = '0;
    mem = (f.kind == K_LD) || (f.kind == K_ST);
    if (k == 0) e.ir_we = 1'b1;
    if (k >= 1) e.extop = f.ext;
    if (k == 1) e.cmpop = f.cmp;
    if (k >= 2) begin e.alua = f.a; e.alub = f.b; e.aluop = f.op; end
    if (k >= 3 && mem) e.dmop = f.dmop;
    if (k == 3) begin e.dm_re = (f.kind == K_LD); e.dm_we = (f.kind == K_ST); end
    if (k == 2 && f.kind == K_MD) begin e.md_start = 1'b1; e.md_op = f.mdop; end
    if (k == 2 && f.kind == K_MT) e.hilo_we = f.hilo;
    if (k >= 3 && f.kind == K_MD) e.busy = 1'b1;
    if (k == f.lat - 1) begin
      e.pc_we = 1'b1;
      case (f.kind)
        K_BR:        e.npcsel = c ? 2'd1 : 2'd0;
        K_J, K_JAL:  begin e.npcsel = 2'd1; e.npcop = 2'd1; end
        K_JR, K_JALR: e.npcsel = 2'd2;
        default: ;
      endcase
      if (f.kind inside {K_ALU, K_JAL, K_JALR, K_MF, K_LD}) begin
        e.grf_we  = 1'b1;
        e.a3sel   = f.a3;
        e.wdsel   = f.wd;
        e.hilosel = f.hisel;
      end
    end
    return e;
  endfunction

  function automatic logic [5:0] r_funct(input int i);
    case (i)
      0: return 6'h21;  1: return 6'h23;  2: return 6'h2a;  3: return 6'h24;
      4: return 6'h00;  5: return 6'h08;  6: return 6'h09;  7: return 6'h10;
      8: return 6'h11;  9: return 6'h12; 10: return 6'h13; 11: return 6'h18;
      12: return 6'h19; 13: return 6'h1a; 14: return 6'h1b;
      default: return 6'h3f;
    endcase
  endfunction

  function automatic logic [5:0] i_op(input int i);
    case (i)
      0: return 6'h09;  1: return 6'h0c;  2: return 6'h0d;  3: return 6'h0f;
      4: return 6'h23;  5: return 6'h20;  6: return 6'h24;  7: return 6'h2b;
      8: return 6'h28;  9: return 6'h04; 10: return 6'h05; 11: return 6'h06;
      12: return 6'h07; 13: return 6'h02; 14: return 6'h03; 15: return 6'h01;
      default: return 6'h3f;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    ins = $urandom;
    if ($urandom_range(0, 1) == 0) begin
      ins[31:26] = 6'h00;
      ins[5:0]   = r_funct(int'($urandom_range(0, 15)));
    end else begin
      ins[31:26] = i_op(int'($urandom_range(0, 16)));
      if (ins[31:26] == 6'h01) ins[20:16] = 5'($urandom_range(0, 2));
    end
    return ins;
  endfunction

  task automatic drive(input int d, input logic [31:0] ins, input logic c, input logic r);
    ir_s[d]  = ins;
    cmp_s[d] = c;
    rst_s[d] = r;
  endtask

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic reset_cycles(input int d, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      drive(d, $urandom, 1'b0, 1'b1);
      e.v = '0; e.rst = 1'b1; e.ins = 32'h0; e.k = -1;
      push(d, e);
      @(posedge clk); #1;
    end
  endtask

  // rst_at: -1 none, -2 random chance; cmp_force: -1 random, else the DECODE-cycle comparator value.
  task automatic run_instr(input int d, input logic [31:0] ins, input int rst_at, input int cmp_force);
    info_t f;
    exp_t  e;
    int    r_at;
    logic  c;
    f    = classify(ins, d == 0 ? 5 : 3, d == 0 ? 10 : 1);
    r_at = rst_at;
    if (rst_at == -2)
      r_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, f.lat - 1)) : -1;
    for (int k = 0; k < f.lat; k++) begin
      c = (cmp_force >= 0 && k == 1) ? cmp_force[0] : 1'($urandom_range(0, 1));
      drive(d, (k == 0) ? $urandom : ins, c, k == r_at);
      e.v   = (k == r_at) ? ctl_t'('0) : exp_at(f, k, c);
      e.rst = (k == r_at);
      e.ins = ins;
      e.k   = k;
      push(d, e);
      @(posedge clk); #1;
      if (k == r_at) break;
    end
  endtask

  task automatic stream0();
    reset_cycles(0, 2);
    run_instr(0, 32'h00221821, -1, -1);  // addu $3,$1,$2
    run_instr(0, 32'h8C040008, -1, -1);  // lw $4,8($0)
    run_instr(0, 32'hAC040008, -1, -1);  // sw $4,8($0)
    run_instr(0, 32'h10220004, -1, 1);   // beq taken
    run_instr(0, 32'h10220004, -1, 0);   // beq not taken
    run_instr(0, 32'h00220018, -1, -1);  // mult
    run_instr(0, 32'h0022001A, 4, -1);   // div aborted by reset in MDU_WAIT
    run_instr(0, 32'h0C000010, -1, -1);  // jal
    run_instr(0, 32'hFC000000, -1, -1);  // unknown opcode
    run_instr(0, 32'h00200011, -1, -1);  // mthi
    run_instr(0, 32'h00001810, -1, -1);  // mfhi
    run_instr(0, 32'h0020F809, -1, -1);  // jalr
    for (int i = 0; i < 300; i++) run_instr(0, rand_instr(), -2, -1);
  endtask

  task automatic stream1();
    reset_cycles(1, 2);
    run_instr(1, 32'h0022001A, -1, -1);  // div with single-cycle latency
    run_instr(1, 32'h00220019, -1, -1);  // multu
    run_instr(1, 32'h0022001B, -1, -1);  // divu
    for (int i = 0; i < 300; i++) run_instr(1, rand_instr(), -2, -1);
  endtask

  task automatic check(input int d, input exp_t e, input ctl_t got);
    ctl_t m;
    m = e.rst ? en_mask : ctl_t'('1);
    checks++;
    if ((got & m) !== (e.v & m)) begin
      errors++;
      $display("FAIL dut%0d %s ins=%h k=%0d got=%h exp=%h",
               d, e.rst ? "reset_enables" : "ctl", e.ins, e.k, got & m, e.v & m);
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) check(0, q0.pop_front(), g_dut[0].o);
    if (q1.size() > 0) check(1, q1.pop_front(), g_dut[1].o);
  end

  initial begin
    en_mask          = '0;
    en_mask.ir_we    = 1'b1;
    en_mask.pc_we    = 1'b1;
    en_mask.dm_re    = 1'b1;
    en_mask.dm_we    = 1'b1;
    en_mask.grf_we   = 1'b1;
    en_mask.md_start = 1'b1;
    en_mask.hilo_we  = 2'b11;
    for (int d = 0; d < 2; d++) drive(d, 32'h0, 1'b0, 1'b1);
    @(posedge clk); #1;
    fork
      stream0();
      stream1();
    join
    repeat (2) @(posedge clk);
    checks++;
    if (q0.size() + q1.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", q0.size() + q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle MIPS control unit: a state machine that sequences each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Supports multiply/divide with parametrised latency through a dedicated wait state, plus HI/LO moves.
- Sits between IR and the shared datapath (NPC, CMP, EXT, ALU, DM, GRF, MDU). It replaces single-cycle decoding for the multi-cycle core.
- Control encodings match the single-cycle controller, so datapath muxes are reused unchanged.

Parameters:
- MULT_CYCLES, 5: total MDU cycles for mult/multu, counted from the MD_start cycle; must be ≥1.
- DIV_CYCLES, 10: total MDU cycles for div/divu; must be ≥1.
- CNT_W, 4: width of the latency counter; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- IR  in  32  instruction register contents, valid from DECODE onward.
- cmp_true  in  1  comparator result for the current CMPOp, combinational, valid in DECODE.
- IR_WE  out  1  load IR from instruction memory.
- PC_WE  out  1  commit NPC to PC.
- NPCsel  out  2  0 = PC+4, 1 = NPC unit (branch/jump), 2 = GRF[rs].
- NPCOp  out  2  0 = branch offset, 1 = j/jal index.
- CMPOp  out  4  0 eq, 1 gez, 2 gtz, 3 lez, 4 ltz, 5 ne.
- ExtOp  out  2  0 sign, 1 zero, 2 lui.
- ALUasel  out  2  ALU A-input select, same encoding as single-cycle.
- ALUbsel  out  2  ALU B-input select, same encoding as single-cycle.
- ALUOp  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0110 sll, 0111 slt.
- DM_RE  out  1  data memory read enable.
- DM_WE  out  1  data memory write enable.
- DMOp  out  2  0 word, 1 byte store, 2 lb, 3 lbu.
- A3sel  out  2  0 rd, 1 rt, 3 $31.
- WDsel  out  2  0 ALU, 1 DM, 2 HI/LO.
- GRF_WE  out  1  register file write enable.
- MD_start  out  1  one-cycle start pulse to MDU.
- MD_op  out  2  0 mult, 1 multu, 2 div, 3 divu.
- HILO_WE  out  2  bit1 writes HI (mthi), bit0 writes LO (mtlo).
- HILOsel  out  1  0 LO, 1 HI (mflo/mfhi read).
- busy  out  1  high while in MDU_WAIT.

Behaviour:
- Reset (synchronous, priority over all): state ← FETCH, counter ← 0.
  - Every output is a function of state and IR only; all enables are 0 in every cycle except where listed below. Selects are 0 when unused.
  - Reset asserted mid-instruction (including MDU_WAIT) aborts it; no PC_WE/GRF_WE/DM_WE in the reset cycle.
- FETCH: IR_WE=1 → DECODE.
- DECODE: ExtOp and CMPOp driven from IR.
  - beq/bne/bgtz/blez/bgez/bltz: PC_WE=1, NPCsel = cmp_true ? 1 : 0, NPCOp=0 → FETCH. Total 2 cycles.
  - j: PC_WE=1, NPCsel=1, NPCOp=1 → FETCH.
  - jr: PC_WE=1, NPCsel=2 → FETCH.
  - Unknown opcode/func: nop, PC_WE=1, NPCsel=0 → FETCH.
  - All other instructions → EXEC.
- EXEC: ALUasel, ALUbsel, ALUOp driven per instruction.
  - addu, subu, slt, and, sll, andi, ori, lui, addiu, jal, jalr, mfhi, mflo → WB.
  - lw/lb/lbu/sw/sb → MEM.
  - mthi/mtlo: HILO_WE set, PC_WE=1, NPCsel=0 → FETCH.
  - mult/multu/div/divu: MD_start=1, MD_op set, counter ← LAT−1, where LAT is MULT_CYCLES or DIV_CYCLES.
    - LAT=1: PC_WE=1 → FETCH.
    - Otherwise → MDU_WAIT.
- MDU_WAIT: busy=1; counter decrements each cycle.
  - When counter==1: PC_WE=1, NPCsel=0 → FETCH.
  - Instruction total = LAT+2 cycles (FETCH + DECODE + LAT).
- MEM: DM_RE=1 for loads; DM_WE=1 for stores.
  - Stores: PC_WE=1 → FETCH (4 cycles).
  - Loads → WB.
- WB: GRF_WE=1, with A3sel and WDsel per instruction (loads WDsel=1; mfhi/mflo WDsel=2).
  - PC_WE=1. NPCsel=0, except jal (NPCsel=1, NPCOp=1) and jalr (NPCsel=2).
  - Link value is PC+4, routed via ALU with ALUasel=1, ALUbsel=2.
  - → FETCH. Loads take 5 cycles; others 4.
- Invariants:
  - PC_WE is asserted exactly once per instruction.
  - IR_WE is asserted only in FETCH.
  - GRF_WE and DM_WE are never asserted in the same cycle.
  - Writes to $0 are not suppressed here.

Test Plan:
- Reset, then addu $3,$1,$2 (0x00221821) → IR_WE@c0, ALUOp=0000@c2, GRF_WE=1, A3sel=0, WDsel=0, PC_WE=1@c3; next IR_WE@c4.
- lw $4,8($0) (0x8C040008) → ExtOp=0@c1, DM_RE=1@c3, GRF_WE=1, A3sel=1, WDsel=1, PC_WE@c4; sw (0xAC040008) → DM_WE@c3, PC_WE@c3, GRF_WE never.
- beq $1,$2 (0x10220004) with cmp_true=1 → PC_WE=1, NPCsel=1@c1; with cmp_true=0 → NPCsel=0@c1; next fetch @c2 in both cases.
- mult $1,$2 (0x00220018), MULT_CYCLES=5 → MD_start=1, MD_op=0@c2; busy=1 c3–c6; PC_WE@c6; next IR_WE@c7. Rerun with DIV_CYCLES=1, div → PC_WE@c2, busy never.
- reset asserted @c4 during div (MDU_WAIT) → c5 in FETCH, busy=0, no PC_WE in the abort cycle.
- jal 0x0C000010 → WB@c3: GRF_WE=1, A3sel=3, NPCsel=1, NPCOp=1, PC_WE=1; unknown opcode 0xFC000000 → PC_WE@c1 only.
